ddr_burst_arbiter: RTL and testbench

- Parametrised N-channel round-robin arbiter in front of the DDR3 memory-controller native command/data port.
- Multiplexes burst requests from the video clients onto the single controller port, for example the HDMI RX frame writer and the HDMI TX frame reader.
- One burst is in flight at a time. The grant is held until every beat of that burst has transferred.
- Sits between the video DMA engines and the DDR3 controller in the sys_clk domain. Successor to the fixed two-port hookup: adds channel count, burst length and width generality, plus fair arbitration.

---
 rtl/ddr_arb_pkg.sv | 26 ++
 rtl/rr_arbiter_pick.sv | 46 ++++
 rtl/ddr_burst_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR3 burst arbiter.
package ddr_arb_pkg;

   // Burst sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      WDATA = 3'd2,
      RDATA = 3'd3,
      DONE  = 3'd4
   } arb_state_e;

   // Channel count of the default build and the matching index width
   localparam int DEF_NUM_CH = 4;
   localparam int CH_IDX_W   = $clog2(DEF_NUM_CH);

   // Index width for an arbitrary channel count (at least one bit)
   function automatic int ch_idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first requester at or after ptr, with
// wrap. In priority mode channel 0 wins outright and is excluded from the
// rotation among the other channels.
module rr_arbiter_pick
   import ddr_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   input  logic              prio_en_i,
   output logic [IDX_W-1:0]  gnt_idx_o,
   output logic              gnt_valid_o
);

   logic [IDX_W:0] idx;

   // Scan NUM_CH candidates starting at ptr and keep the first hit
   always_comb begin
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      idx         = '0;
      if (prio_en_i && req_i[0]) begin
         gnt_idx_o   = '0;
         gnt_valid_o = 1'b1;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_CH)) begin
               idx = idx - (IDX_W+1)'(NUM_CH);
            end else begin
               idx = idx;
            end
            if (!gnt_valid_o && req_i[idx[IDX_W-1:0]] &&
                !(prio_en_i && (idx == '0))) begin
               gnt_idx_o   = idx[IDX_W-1:0];
               gnt_valid_o = 1'b1;
            end else begin
               gnt_valid_o = gnt_valid_o;
            end
         end
      end
   end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// N-channel round-robin burst arbiter in front of the DDR3 controller
// native port. One burst in flight; grant held until its last beat.
// Optional build macro: DDR_ARB_PRIORITY_EN (channel 0 always wins).
module ddr_burst_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int LEN_W  = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_we,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH*LEN_W-1:0]    ch_len,
   output logic [NUM_CH-1:0]          ch_gnt,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]          ch_wready,
   output logic [DATA_W-1:0]          ch_rdata,
   output logic [NUM_CH-1:0]          ch_rvalid,
   output logic [NUM_CH-1:0]          ch_done,
   output logic                       mc_cmd_valid,
   input  logic                       mc_cmd_ready,
   output logic                       mc_cmd_we,
   output logic [ADDR_W-1:0]          mc_cmd_addr,
   output logic [LEN_W-1:0]           mc_cmd_len,
   output logic                       mc_wvalid,
   input  logic                       mc_wready,
   output logic [DATA_W-1:0]          mc_wdata,
   input  logic                       mc_rvalid,
   input  logic [DATA_W-1:0]          mc_rdata,
   output logic                       err_stray
);

   localparam int IDX_W = ch_idx_w(NUM_CH);

`ifdef DDR_ARB_PRIORITY_EN
   localparam logic PRIO_EN = 1'b1;
`else
   localparam logic PRIO_EN = 1'b0;
`endif

   arb_state_e          state_q;
   logic [IDX_W-1:0]    g_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    ptr_d;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [NUM_CH-1:0]   gnt_q;
   logic [NUM_CH-1:0]   done_q;
   logic                cmd_valid_q;
   logic                err_q;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_valid;

   function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   rr_arbiter_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req_i       (ch_req),
      .ptr_i       (ptr_q),
      .prio_en_i   (PRIO_EN),
      .gnt_idx_o   (pick_idx),
      .gnt_valid_o (pick_valid)
   );

   // Next rotation start: channel after the one just served, skipping 0 in priority mode
   always_comb begin
      if (g_q == IDX_W'(NUM_CH-1)) begin
         ptr_d = PRIO_EN ? IDX_W'(1) : IDX_W'(0);
      end else begin
         ptr_d = g_q + IDX_W'(1);
      end
   end

   // Burst sequencer: grant, command handshake, beat counting, done pulse
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         g_q         <= '0;
         ptr_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (mc_rvalid && (state_q != RDATA)) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  g_q         <= pick_idx;
                  addr_q      <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
                  len_q       <= ch_len[pick_idx*LEN_W +: LEN_W];
                  we_q        <= ch_we[pick_idx];
                  gnt_q       <= onehot(pick_idx);
                  cmd_valid_q <= 1'b1;
                  state_q     <= CMD;
               end
            end
            CMD: begin
               gnt_q <= '0;
               if (mc_cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= we_q ? WDATA : RDATA;
               end
            end
            WDATA: begin
               if (mc_wready) begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  if (cnt_q == len_q) begin
                     done_q  <= onehot(g_q);
                     state_q <= DONE;
                  end
               end
            end
            RDATA: begin
               if (mc_rvalid) begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  if (cnt_q == len_q) begin
                     done_q  <= onehot(g_q);
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               done_q  <= '0;
               ptr_q   <= ptr_d;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Data path steering to/from the granted channel during the data phase
   always_comb begin
      mc_wvalid = 1'b0;
      mc_wdata  = '0;
      ch_wready = '0;
      ch_rdata  = '0;
      ch_rvalid = '0;
      if (state_q == WDATA) begin
         mc_wvalid = 1'b1;
         mc_wdata  = ch_wdata[g_q*DATA_W +: DATA_W];
         ch_wready = mc_wready ? onehot(g_q) : '0;
      end else if (state_q == RDATA) begin
         ch_rdata  = mc_rdata;
         ch_rvalid = mc_rvalid ? onehot(g_q) : '0;
      end else begin
         mc_wvalid = 1'b0;
      end
   end

   assign ch_gnt       = gnt_q;
   assign ch_done      = done_q;
   assign mc_cmd_valid = cmd_valid_q;
   assign mc_cmd_we    = we_q;
   assign mc_cmd_addr  = addr_q;
   assign mc_cmd_len   = len_q;
   assign err_stray    = err_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter: randomized clients and
// controller, a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ddr_burst_arbiter;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int LEN_W  = 8;
`ifdef DDR_ARB_PRIORITY_EN
   localparam bit PRIO = 1'b1;
   localparam int FAIR_EXP [5] = '{0, 0, 0, 0, 0};
   localparam int PRIO_EXP [4] = '{0, 0, 0, 0};
`else
   localparam bit PRIO = 1'b0;
   localparam int FAIR_EXP [5] = '{0, 1, 2, 3, 0};
   localparam int PRIO_EXP [4] = '{0, 2, 0, 2};
`endif
   localparam int PH_IDLE = 0, PH_CMD = 1, PH_WR = 2, PH_RD = 3, PH_DONE = 4;

   logic                     sys_clk = 1'b0;
   logic                     sys_rst = 1'b1;
   logic [NUM_CH-1:0]        ch_req = '0, ch_we = '0;
   logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
   logic [NUM_CH*LEN_W-1:0]  ch_len = '0;
   logic [NUM_CH*DATA_W-1:0] ch_wdata = '0;
   logic [NUM_CH-1:0]        ch_gnt, ch_wready, ch_rvalid, ch_done;
   logic [DATA_W-1:0]        ch_rdata, mc_wdata;
   logic [DATA_W-1:0]        mc_rdata = '0;
   logic                     mc_cmd_valid, mc_cmd_we, mc_wvalid, err_stray;
   logic                     mc_cmd_ready = 1'b0, mc_wready = 1'b0, mc_rvalid = 1'b0;
   logic [ADDR_W-1:0]        mc_cmd_addr;
   logic [LEN_W-1:0]         mc_cmd_len;

   always #5 sys_clk = ~sys_clk;

   ddr_burst_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_req(ch_req), .ch_we(ch_we),
      .ch_addr(ch_addr), .ch_len(ch_len), .ch_gnt(ch_gnt), .ch_wdata(ch_wdata),
      .ch_wready(ch_wready), .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_done(ch_done),
      .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_cmd_we(mc_cmd_we),
      .mc_cmd_addr(mc_cmd_addr), .mc_cmd_len(mc_cmd_len), .mc_wvalid(mc_wvalid),
      .mc_wready(mc_wready), .mc_wdata(mc_wdata), .mc_rvalid(mc_rvalid),
      .mc_rdata(mc_rdata), .err_stray(err_stray));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus configuration ----------------
   int              shots [NUM_CH];
   int              rate = 100;
   bit              fix_en = 1'b1;
   logic [LEN_W-1:0] fix_len [NUM_CH];
   logic            fix_we [NUM_CH];
   int              len_max = 15;
   int              cmd_delay = 0;     // <0: random ready
   int              wr_mode = 0;       // 0 random, 1 toggle, 2 always
   int              rd_rate = 100;
   bit              stray_pulse = 1'b0;
   bit              cbusy [NUM_CH];
   logic [31:0]     wseq [NUM_CH];
   logic [ADDR_W-1:0] raised_addr [NUM_CH];
   int              cmd_wait = 0;
   int              rd_pending = 0;

   // ---------------- monitor observations ----------------
   bit              hs_w [NUM_CH];
   bit              hs_cmd = 1'b0, hs_cmd_we = 1'b0;
   logic [LEN_W-1:0] hs_cmd_len = '0;
   int              cyc = 0, cur_beats = 0, last_beats = 0, last_beat_cyc = 0, done_cyc = 0;
   int              done_total = 0;
   int              gnt_log [$];
   logic [DATA_W-1:0] wlog [$];
   logic [NUM_CH-1:0] rvlog [$];
   logic [ADDR_W-1:0] cmdaddr_log [$];
   bit              mon_en = 1'b0;

   // ---------------- reference model state ----------------
   int              mph = PH_IDLE, mptr = 0, mg = 0, mrem = 0;
   logic            mwe = 1'b0, merr = 1'b0, mfirst = 1'b0;
   logic [ADDR_W-1:0] maddr = '0;
   logic [LEN_W-1:0]  mlen = '0;

   function automatic int model_pick(input logic [NUM_CH-1:0] r, input int p);
      if (PRIO && r[0]) return 0;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (p + k) % NUM_CH;
         if (!(PRIO && c == 0) && r[c]) return c;
      end
      return -1;
   endfunction

   function automatic int oh2idx(input logic [NUM_CH-1:0] v);
      for (int k = 0; k < NUM_CH; k++) if (v[k]) return k;
      return -1;
   endfunction

   function automatic logic [NUM_CH-1:0] oh(input int i);
      logic [NUM_CH-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Client and controller behaviour, driven just after each rising edge
   initial begin : drv
      for (int i = 0; i < NUM_CH; i++) begin
         shots[i] = 0; fix_len[i] = '0; fix_we[i] = 1'b0; cbusy[i] = 1'b0; wseq[i] = '0;
         raised_addr[i] = '0;
      end
      forever begin
         @(posedge sys_clk);
         #1;
         mc_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (sys_rst) begin
            ch_req = '0;
            for (int i = 0; i < NUM_CH; i++) cbusy[i] = 1'b0;
            rd_pending = 0; cmd_wait = 0;
            mc_cmd_ready = 1'b0; mc_rvalid = 1'b0; mc_wready = 1'b0;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (hs_w[i]) wseq[i] = wseq[i] + 32'd1;
               if (ch_gnt[i]) begin ch_req[i] = 1'b0; cbusy[i] = 1'b1; end
               if (ch_done[i]) cbusy[i] = 1'b0;
               if (!ch_req[i] && !cbusy[i] && shots[i] != 0 && $urandom_range(99, 0) < rate) begin
                  raised_addr[i] = ADDR_W'($urandom);
                  ch_addr[i*ADDR_W +: ADDR_W] = raised_addr[i];
                  ch_len[i*LEN_W +: LEN_W] = fix_en ? fix_len[i] : LEN_W'($urandom_range(len_max, 0));
                  ch_we[i] = fix_en ? fix_we[i] : 1'($urandom);
                  ch_req[i] = 1'b1;
                  if (shots[i] > 0) shots[i]--;
               end
               ch_wdata[i*DATA_W +: DATA_W] = {32'(i), 64'd0, wseq[i]};
            end
            // controller side
            if (mc_cmd_valid) begin
               mc_cmd_ready = (cmd_delay < 0) ? 1'($urandom) : (cmd_wait >= cmd_delay);
               cmd_wait++;
            end else begin
               mc_cmd_ready = 1'b0; cmd_wait = 0;
            end
            if (wr_mode == 1) mc_wready = ~mc_wready;
            else if (wr_mode == 2) mc_wready = 1'b1;
            else mc_wready = 1'($urandom);
            if (hs_cmd && !hs_cmd_we) rd_pending = int'(hs_cmd_len) + 1;
            if (rd_pending > 0 && $urandom_range(99, 0) < rd_rate) begin
               mc_rvalid = 1'b1; rd_pending--;
            end else if (stray_pulse && rd_pending == 0) begin
               mc_rvalid = 1'b1; stray_pulse = 1'b0;
            end else begin
               mc_rvalid = 1'b0;
            end
         end
      end
   end

   // Monitor: log observations, compare against model, then advance model
   always @(negedge sys_clk) begin
      cyc++;
      for (int i = 0; i < NUM_CH; i++) hs_w[i] = ch_wready[i];
      hs_cmd = mc_cmd_valid && mc_cmd_ready; hs_cmd_we = mc_cmd_we; hs_cmd_len = mc_cmd_len;
      if (|ch_gnt) begin gnt_log.push_back(oh2idx(ch_gnt)); cur_beats = 0; end
      if ((mc_wvalid && mc_wready) || (|ch_rvalid)) begin cur_beats++; last_beat_cyc = cyc; end
      if (mc_wvalid && mc_wready) wlog.push_back(mc_wdata);
      if (|ch_rvalid) rvlog.push_back(ch_rvalid);
      if (mc_cmd_valid && mc_cmd_ready) cmdaddr_log.push_back(mc_cmd_addr);
      if (|ch_done) begin last_beats = cur_beats; done_cyc = cyc; done_total++; end

      if (mon_en) begin
         chk("err_stray", err_stray, merr);
         case (mph)
            PH_IDLE: chk("idle_outs", {ch_gnt, ch_done, mc_cmd_valid, mc_wvalid, ch_wready, ch_rvalid}, '0);
            PH_CMD: begin
               chk("cmd_fields", {mc_cmd_valid, mc_cmd_we, mc_cmd_addr, mc_cmd_len}, {1'b1, mwe, maddr, mlen});
               chk("cmd_gnt", {ch_gnt, ch_done, mc_wvalid, ch_rvalid}, {(mfirst ? oh(mg) : '0), 4'b0, 1'b0, 4'b0});
            end
            PH_WR: begin
               chk("wr_ctl", {mc_cmd_valid, mc_wvalid, ch_wready, ch_rvalid, ch_done},
                   {1'b0, 1'b1, (mc_wready ? oh(mg) : 4'b0), 4'b0, 4'b0});
               chk("wr_data", mc_wdata, ch_wdata[mg*DATA_W +: DATA_W]);
            end
            PH_RD: begin
               chk("rd_ctl", {mc_cmd_valid, mc_wvalid, ch_wready, ch_rvalid, ch_done},
                   {1'b0, 1'b0, 4'b0, (mc_rvalid ? oh(mg) : 4'b0), 4'b0});
               chk("rd_data", ch_rdata, mc_rdata);
            end
            default: chk("done_outs", {ch_done, ch_gnt, mc_cmd_valid, mc_wvalid, ch_rvalid}, {oh(mg), 4'b0, 2'b0, 4'b0});
         endcase
      end

      if (sys_rst) begin
         mph = PH_IDLE; mptr = 0; merr = 1'b0; mfirst = 1'b0;
      end else begin
         if (mc_rvalid && mph != PH_RD) merr = 1'b1;
         mfirst = 1'b0;
         case (mph)
            PH_IDLE: begin
               mg = model_pick(ch_req, mptr);
               if (mg >= 0) begin
                  maddr = ch_addr[mg*ADDR_W +: ADDR_W]; mlen = ch_len[mg*LEN_W +: LEN_W];
                  mwe = ch_we[mg]; mfirst = 1'b1; mph = PH_CMD;
               end else mg = 0;
            end
            PH_CMD: if (mc_cmd_ready) begin mph = mwe ? PH_WR : PH_RD; mrem = int'(mlen) + 1; end
            PH_WR: if (mc_wready) begin mrem--; if (mrem == 0) mph = PH_DONE; end
            PH_RD: if (mc_rvalid) begin mrem--; if (mrem == 0) mph = PH_DONE; end
            default: begin
               mptr = (mg + 1) % NUM_CH;
               if (PRIO && mptr == 0) mptr = 1;
               mph = PH_IDLE;
            end
         endcase
      end
   end

   task automatic do_reset();
      @(posedge sys_clk); #2;
      for (int i = 0; i < NUM_CH; i++) shots[i] = 0;
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst = 1'b0;
      gnt_log.delete(); wlog.delete(); rvlog.delete(); cmdaddr_log.delete();
   endtask

   task automatic wait_dones(input int n, input int lim, input string nm);
      int t;
      int target;
      t = 0; target = done_total + n;
      while (done_total < target && t < lim) begin @(posedge sys_clk); t++; end
      #2;
      chk({nm, "_timeout"}, done_total >= target, 1'b1);
   endtask

   task automatic wait_grants(input int n, input int lim, input string nm);
      int t;
      t = 0;
      while (gnt_log.size() < n && t < lim) begin @(posedge sys_clk); t++; end
      #2;
      chk({nm, "_timeout"}, gnt_log.size() >= n, 1'b1);
   endtask

   initial begin : main
      int t;
      int done_before;
      repeat (2) @(posedge sys_clk);
      #2 mon_en = 1'b1;

      // 1: ch1 write, len=3, delayed command ready, toggling wready
      do_reset();
      fix_en = 1'b1; fix_len[1] = 8'd3; fix_we[1] = 1'b1; cmd_delay = 2; wr_mode = 1; rate = 100;
      shots[1] = 1;
      wait_dones(1, 200, "wr1");
      chk("wr1_gnt_count", gnt_log.size(), 1);
      chk("wr1_gnt_ch", gnt_log[0], 1);
      chk("wr1_cmd_addr", cmdaddr_log[0], raised_addr[1]);
      chk("wr1_beats", last_beats, 4);
      chk("wr1_wlog_size", wlog.size(), 4);
      for (int k = 0; k < 4; k++) chk("wr1_beat_data", wlog[k], {32'd1, 64'd0, 32'(k)});
      chk("wr1_done_latency", done_cyc - last_beat_cyc, 1);

      // 2: ch2 single-beat read
      do_reset();
      fix_len[2] = 8'd0; fix_we[2] = 1'b0; cmd_delay = 0; rd_rate = 100; wr_mode = 0;
      shots[2] = 1;
      wait_dones(1, 200, "rd1");
      chk("rd1_gnt_ch", gnt_log[0], 2);
      chk("rd1_beats", last_beats, 1);
      chk("rd1_rvalid_count", rvlog.size(), 1);
      chk("rd1_rvalid_vec", rvlog[0], 4'b0100);

      // 3: fairness with all four channels requesting continuously
      do_reset();
      for (int i = 0; i < NUM_CH; i++) begin fix_len[i] = 8'd1; fix_we[i] = 1'(i % 2 == 0); end
      cmd_delay = -1; rd_rate = 70;
      for (int i = 0; i < NUM_CH; i++) shots[i] = -1;
      wait_grants(5, 400, "fair");
      for (int k = 0; k < 5; k++) chk("fair_order", gnt_log[k], FAIR_EXP[k]);

      // 4: ch0 and ch2 requesting continuously
      do_reset();
      shots[0] = -1; shots[2] = -1;
      wait_grants(4, 400, "prio");
      for (int k = 0; k < 4; k++) chk("prio_order", gnt_log[k], PRIO_EXP[k]);

      // 5: stray read data in IDLE, then a 256-beat read
      do_reset();
      @(posedge sys_clk); #2 stray_pulse = 1'b1;
      repeat (4) @(posedge sys_clk);
      #2 chk("stray_set", err_stray, 1'b1);
      fix_len[3] = 8'd255; fix_we[3] = 1'b0; rd_rate = 60; shots[3] = 1;
      wait_dones(1, 2000, "maxlen");
      chk("maxlen_beats", last_beats, 256);
      chk("stray_sticky", err_stray, 1'b1);
      do_reset();
      chk("stray_cleared", err_stray, 1'b0);

      // 6: reset in the middle of an 8-beat write
      fix_len[2] = 8'd0; fix_we[2] = 1'b0; rd_rate = 100; cmd_delay = 0; shots[2] = 1;
      wait_dones(1, 200, "pre_ptr");
      fix_len[1] = 8'd7; fix_we[1] = 1'b1; wr_mode = 1; shots[1] = 1;
      t = 0;
      while (!(gnt_log.size() >= 2 && cur_beats >= 2) && t < 200) begin @(posedge sys_clk); t++; end
      #2;
      chk("midrst_reach_beat2", cur_beats >= 2, 1'b1);
      done_before = done_total;
      sys_rst = 1'b1;
      @(posedge sys_clk); @(negedge sys_clk); #1;
      chk("midrst_ctl_zero", {ch_gnt, ch_done, ch_wready, ch_rvalid, mc_cmd_valid, mc_cmd_we,
                              mc_cmd_addr, mc_cmd_len, mc_wvalid, err_stray}, '0);
      chk("midrst_data_zero", {mc_wdata, ch_rdata}, '0);
      @(posedge sys_clk); #2 sys_rst = 1'b0;
      repeat (6) @(posedge sys_clk);
      #2 chk("midrst_no_done", done_total, done_before);
      gnt_log.delete();
      fix_len[1] = 8'd0; fix_len[3] = 8'd0; fix_we[3] = 1'b0;
      shots[1] = 1; shots[3] = 1;
      wait_dones(2, 200, "post_rst");
      chk("post_rst_ptr0", gnt_log[0], 1);

      // 7: randomized traffic
      do_reset();
      fix_en = 1'b0; len_max = 15; rate = 30; cmd_delay = -1; wr_mode = 0; rd_rate = 60;
      for (int i = 0; i < NUM_CH; i++) shots[i] = -1;
      repeat (4000) @(posedge sys_clk);
      #2 chk("random_progress", done_total > done_before + 20, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
